word_loader: RTL
================

// Module: word_loader
// PURPOSE
// - Upstream feeder of the vocabulary encoder. Consumes a character stream over a valid/ready handshake.
// - Writes the stream into the encoder's input SRAM as zero-terminated words, then a final 0x00 end marker.
// - The end marker yields the double-zero the encoder uses to detect end of text.
// - Separators are collapsed so no empty words are produced. Pulses done when the image is complete.
// PARAMETERS
// - ADDR_WIDTH  4  SRAM address width; DEPTH = 2**ADDR_WIDTH entries
// - DATA_WIDTH  8  character / SRAM word width
// PORTS
// - clk         in   1           single clock, all logic on posedge
// - rst         in   1           reset: one clock; reset is synchronous and active-high
// - cs          in   1           start request, sampled in IDLE only
// - in_valid    in   1           character beat valid
// - in_data     in   DATA_WIDTH  character; 0x20 and 0x00 are separators
// - in_last     in   1           qualifies final beat of the stream
// - in_ready    out  1           loader accepts beat (1 only in RECV)
// - we          out  1           SRAM write enable, one-cycle pulse per write
// - addr        out  ADDR_WIDTH  SRAM write address
// - din         out  DATA_WIDTH  SRAM write data
// - word_count  out  ADDR_WIDTH  words written (terminators emitted)
// - overflow    out  1           sticky: characters dropped for lack of space
// - done        out  1           image complete; held until next start
// BEHAVIOUR
// - Reset values: state=IDLE, ptr=0, prev_sep=1, we=0, addr=0, din=0, in_ready=0, word_count=0, overflow=0, done=0.
// - Reset mid-operation: abandons the stream at the next edge. SRAM contents are not cleared.
// - Transfer occurs on a cycle with in_valid & in_ready. we/addr/din are registered: the write appears the cycle after the transfer.
// - Writes go to the address held in ptr; ptr increments after each write.
// - IDLE: cs=1 -> RECV with ptr=0, prev_sep=1, word_count=0, overflow=0, done=0.
// - RECV, transfer of a separator:
//   - prev_sep=0 -> write 0x00, word_count++, prev_sep=1.
//   - prev_sep=1 -> beat dropped, no write.
// - RECV, transfer of a non-separator:
//   - ptr <= DEPTH-3 -> write char, prev_sep=0.
//   - otherwise -> drop the char, overflow=1. Terminator and end-marker slots are always reserved.
// - Transfer with in_last=1 -> TERM (after processing that beat). cs is ignored outside IDLE/DONE.
// - TERM (in_ready=0): prev_sep=0 -> write 0x00, word_count++. Next state END.
// - END (in_ready=0): write 0x00 end marker at ptr. Next state DONE.
// - DONE: done=1, we=0. cs=0 -> IDLE, with done kept at 1 until the next start.
// - Boundaries:
//   - Leading separators are never written.
//   - An empty stream writes only the end marker at addr 0; word_count=0.
//   - The highest address ever written is DEPTH-1; ptr never wraps.
//   - word_count saturates at DEPTH-1.
// CONFIGURATION
// - LOADER_LOWERCASE_EN defined: non-separator chars 0x41..0x5A are written +0x20 (A-Z folded to a-z). Separator detection and all timing are unchanged.
// - LOADER_LOWERCASE_EN undefined: characters are written verbatim.
// TESTING
// - "hi yo", last on 'o' -> addr0..6 = 68 69 00 79 6F 00 00; word_count=2; done=1; overflow=0.
// - " a  b" (leading and double spaces) -> addr0..4 = 61 00 62 00 00; word_count=2; no write for any extra separator.
// - 20x 'x' with no separator, DEPTH=16 -> 'x' at addr0..13, 00 at addr14, 00 at addr15; word_count=1; overflow=1.
// - Single beat 0x20 with in_last -> only write is addr0=00; word_count=0; done=1.
// - "AbC" -> 61 62 63 00 00 with LOADER_LOWERCASE_EN; 41 62 43 00 00 without.
// - Backpressure and reset:
//   - in_valid toggled randomly -> image identical to the no-stall case; in_ready=0 in IDLE/TERM/END/DONE.
//   - rst after 3 beats -> next cycle we=0, in_ready=0, done=0; a new cs builds a fresh image from addr 0.

Source files
------------

// File: rtl/word_loader.sv
//============================================================================
// Module      : word_loader
// Description : Upstream feeder for the vocabulary encoder. Accepts a
//               character stream over a valid/ready handshake and writes it
//               into the encoder's input SRAM as zero-terminated words,
//               followed by a single 0x00 end marker. Runs of separators
//               (0x20, 0x00) collapse, so no empty words are produced.
//               Pulses/holds done once the image is complete.
// Revision    : 1.0 - initial release
//
// Optional feature macro:
//   LOADER_LOWERCASE_EN - fold non-separator 'A'..'Z' to 'a'..'z' on write.
//
// Ports:
//   clk            in   single clock, all logic on posedge
//   rst            in   synchronous active-high reset
//   i_cs           in   start request, sampled in IDLE/DONE only
//   i_in_valid     in   character beat valid
//   i_in_data      in   character (0x20 and 0x00 are separators)
//   i_in_last      in   final beat of the stream
//   o_in_ready     out  beat accepted (high only while receiving)
//   o_we           out  SRAM write enable, one-cycle pulse per write
//   o_addr         out  SRAM write address
//   o_din          out  SRAM write data
//   o_word_count   out  terminators emitted (saturating)
//   o_overflow     out  sticky: characters dropped for lack of space
//   o_done         out  image complete; held until next start
//============================================================================
`default_nettype none

module word_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cs,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_in_last,
  output logic                  o_in_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_din,
  output logic [ADDR_WIDTH-1:0] o_word_count,
  output logic                  o_overflow,
  output logic                  o_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Last address a character may occupy: the two slots above it are kept
  // free for the closing terminator and the end marker.
  localparam logic [ADDR_WIDTH-1:0] c_CHAR_LIMIT = ADDR_WIDTH'(DEPTH - 3);
  localparam logic [ADDR_WIDTH-1:0] c_WC_MAX     = '1;
  localparam logic [DATA_WIDTH-1:0] c_SPACE      = DATA_WIDTH'(32'h20);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RECV = 3'd1,
    S_TERM = 3'd2,
    S_END  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic                    r_prev_sep;
  logic                    r_in_ready;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_din;
  logic [ADDR_WIDTH-1:0]   r_word_count;
  logic                    r_overflow;
  logic                    r_done;

  logic                    w_xfer;
  logic                    w_is_sep;
  logic [DATA_WIDTH-1:0]   w_char;

  assign w_xfer   = i_in_valid & r_in_ready;
  assign w_is_sep = (i_in_data == c_SPACE) || (i_in_data == '0);

`ifdef LOADER_LOWERCASE_EN
  always_comb begin
    w_char = i_in_data;
    if ((i_in_data >= DATA_WIDTH'(32'h41)) && (i_in_data <= DATA_WIDTH'(32'h5A))) begin
      w_char = i_in_data + DATA_WIDTH'(32'h20);
    end
  end
`else
  assign w_char = i_in_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_prev_sep   <= 1'b1;
      r_in_ready   <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // Write enable is a single-cycle pulse; every write path re-asserts it.
      r_we <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_cs) begin
            r_state      <= S_RECV;
            r_ptr        <= '0;
            r_prev_sep   <= 1'b1;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
            r_in_ready   <= 1'b1;
          end
        end

        S_RECV: begin
          if (w_xfer) begin
            if (w_is_sep) begin
              // Only the first separator after a word closes it; the rest
              // of a separator run (and leading separators) vanish.
              if (!r_prev_sep) begin
                r_we       <= 1'b1;
                r_addr     <= r_ptr;
                r_din      <= '0;
                r_ptr      <= r_ptr + ADDR_WIDTH'(1);
                r_prev_sep <= 1'b1;
                if (r_word_count != c_WC_MAX) begin
                  r_word_count <= r_word_count + ADDR_WIDTH'(1);
                end
              end
            end else if (r_ptr <= c_CHAR_LIMIT) begin
              r_we       <= 1'b1;
              r_addr     <= r_ptr;
              r_din      <= w_char;
              r_ptr      <= r_ptr + ADDR_WIDTH'(1);
              r_prev_sep <= 1'b0;
            end else begin
              // Out of room: the word keeps its open state so it still
              // gets terminated in the reserved slot.
              r_overflow <= 1'b1;
            end

            if (i_in_last) begin
              r_state    <= S_TERM;
              r_in_ready <= 1'b0;
            end
          end
        end

        S_TERM: begin
          if (!r_prev_sep) begin
            r_we       <= 1'b1;
            r_addr     <= r_ptr;
            r_din      <= '0;
            r_ptr      <= r_ptr + ADDR_WIDTH'(1);
            r_prev_sep <= 1'b1;
            if (r_word_count != c_WC_MAX) begin
              r_word_count <= r_word_count + ADDR_WIDTH'(1);
            end
          end
          r_state <= S_END;
        end

        S_END: begin
          // End marker lands at ptr; ptr is not advanced so it can never
          // wrap past the top of the SRAM.
          r_we    <= 1'b1;
          r_addr  <= r_ptr;
          r_din   <= '0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        S_DONE: begin
          if (!i_cs) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_we         = r_we;
  assign o_addr       = r_addr;
  assign o_din        = r_din;
  assign o_word_count = r_word_count;
  assign o_overflow   = r_overflow;
  assign o_done       = r_done;

endmodule

`default_nettype wire
